// File: rtl/mio_pkg.sv
// Shared CPU memory-interface definitions: arbiter state encoding and grant codes.
package mio_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CPU_XFER = 2'd1;
    localparam logic [1:0] ST_DMA_XFER = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        CPU_XFER = ST_CPU_XFER,
        DMA_XFER = ST_DMA_XFER,
        DONE     = ST_DONE
    } arb_state_t;

    // One-hot bus ownership as seen on the grant output
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DMA  = 2'b10;

    function automatic logic [1:0] owner_grant(input arb_state_t st);
        return (st == DMA_XFER) ? GNT_DMA : GNT_CPU;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// 8-bit wait counter for the memory handshake; cleared outside a transfer.
module timeout_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) round-robin arbiter for a single shared memory port,
// with a per-transfer handshake timeout that completes the access with bus_err.
module mem_arbiter
    import mio_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    grant,
    output logic          bus_err
);

    arb_state_t state;
    logic       last_dma;
    logic [7:0] tmo_count;
    logic       in_xfer;
    logic       tmo_en;
    logic       tmo_hit;

    assign in_xfer = (state == CPU_XFER) || (state == DMA_XFER);
    // Waiting only counts once the command is actually on the bus
    assign tmo_en  = in_xfer && mem_req && !mem_ready;
    assign tmo_hit = tmo_en && (tmo_count == 8'(TIMEOUT - 1));

    timeout_counter u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (!in_xfer),
        .en    (tmo_en),
        .count (tmo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_dma  <= 1'b1;
            grant     <= GNT_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            bus_err   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req && (!dma_req || last_dma)) begin
                        state     <= CPU_XFER;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_we    <= cpu_we;
                    end else if (dma_req) begin
                        state     <= DMA_XFER;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        mem_we    <= dma_we;
                    end
                end
                CPU_XFER, DMA_XFER: begin
                    if (!mem_req) begin
                        // Command registers settled last cycle; now present it
                        mem_req <= 1'b1;
                        grant   <= owner_grant(state);
                    end else if (mem_ready || tmo_hit) begin
                        mem_req  <= 1'b0;
                        grant    <= GNT_NONE;
                        state    <= DONE;
                        last_dma <= (state == DMA_XFER);
                        bus_err  <= !mem_ready;
                        if (state == CPU_XFER) begin
                            cpu_ready <= 1'b1;
                            if (mem_ready) cpu_rdata <= mem_rdata;
                        end else begin
                            dma_ready <= 1'b1;
                            if (mem_ready) dma_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level requester/memory model.
module tb_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          cpu_ready, dma_ready;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    grant;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .bus_err(bus_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_mem_cmd"}, {mem_req, mem_we, mem_addr, mem_wdata}, '0);
        chk({tag, "_ready_err"}, {cpu_ready, dma_ready, bus_err}, 3'b000);
        chk({tag, "_rdata"}, {cpu_rdata, dma_rdata}, '0);
    endtask

    task automatic wait_mem_req(input string tag, input int bound, output int steps);
        steps = 0;
        while (!mem_req && steps < bound) begin
            step();
            steps++;
        end
        chk({tag, "_mem_req"}, mem_req, 1'b1);
    endtask

    task automatic finish_xfer(input string tag, input int lat, input logic [DW-1:0] data,
                               input logic [1:0] owner);
        for (int i = 0; i < lat; i++) begin
            step();
            chk({tag, "_early_ready"}, {dma_ready, cpu_ready}, 2'b00);
        end
        mem_ready = 1;
        mem_rdata = data;
        step();
        mem_ready = 0;
        chk({tag, "_ready"}, {dma_ready, cpu_ready}, owner);
        chk({tag, "_bus_err"}, bus_err, 1'b0);
        chk({tag, "_release"}, {grant, mem_req}, 3'b000);
        chk({tag, "_rdata"}, (owner == 2'b01) ? cpu_rdata : dma_rdata, data);
    endtask

    typedef struct {
        bit            dma;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] mdata;
        logic [1:0]    exp_grant;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t tbl[4];

    // Random-phase model state
    bit            exp_c, exp_d, draining;
    logic [DW-1:0] exp_data;
    int            lat, c_gap, d_gap, c_other, d_other, n_done, steps;
    bit            lat_active;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 32'h0000_0100, 32'h0,          3, 32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF};
        tbl[1] = '{1, 1, 32'h0000_0200, 32'hCAFE_0001,  0, 32'h1234_5678, 2'b10, 32'h1234_5678};
        tbl[2] = '{0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF,  1, 32'h0,         2'b01, 32'h0};
        tbl[3] = '{1, 0, 32'h0000_0040, 32'h0,          5, 32'hA5A5_5A5A, 2'b10, 32'hA5A5_5A5A};

        clear_inputs();
        reset = 1;
        step();
        step();
        check_reset_values("reset");
        reset = 0;

        // Single transfers from the vector table
        foreach (tbl[k]) begin
            if (tbl[k].dma) begin
                dma_req = 1; dma_we = tbl[k].we; dma_addr = tbl[k].addr; dma_wdata = tbl[k].wdata;
            end else begin
                cpu_req = 1; cpu_we = tbl[k].we; cpu_addr = tbl[k].addr; cpu_wdata = tbl[k].wdata;
            end
            step();
            chk($sformatf("vec%0d_no_early_req", k), {mem_req, grant}, 3'b000);
            step();
            chk($sformatf("vec%0d_grant", k), {mem_req, grant}, {1'b1, tbl[k].exp_grant});
            chk($sformatf("vec%0d_cmd", k), {mem_we, mem_addr, mem_wdata},
                {tbl[k].we, tbl[k].addr, tbl[k].wdata});
            finish_xfer($sformatf("vec%0d", k), tbl[k].lat, tbl[k].mdata, tbl[k].exp_grant);
            cpu_req = 0; dma_req = 0;
            step();
            chk($sformatf("vec%0d_one_pulse", k), {dma_ready, cpu_ready}, 2'b00);
        end

        // Timeout: DMA read never acknowledged
        dma_req = 1; dma_we = 0; dma_addr = 32'h300;
        step();
        step();
        chk("tmo_grant", {mem_req, grant}, 3'b110);
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            if (i < TIMEOUT) begin
                chk("tmo_early", {dma_ready, bus_err}, 2'b00);
            end else begin
                chk("tmo_pulse", {dma_ready, bus_err, cpu_ready}, 3'b110);
                chk("tmo_rdata_kept", dma_rdata, 32'hA5A5_5A5A);
            end
        end
        dma_req = 0;
        step();
        chk("tmo_pulse_end", {dma_ready, bus_err}, 2'b00);
        step();

        // Simultaneous requests after reset: CPU first, then DMA
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h04; cpu_wdata = 32'h11;
        dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        wait_mem_req("sim_cpu", 6, steps);
        chk("sim_cpu_grant", grant, 2'b01);
        chk("sim_cpu_cmd", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h04, 32'h11});
        finish_xfer("sim_cpu", 0, 32'h77, 2'b01);
        cpu_req = 0;
        wait_mem_req("sim_dma", 6, steps);
        chk("sim_gap_cycles", steps, 3);
        chk("sim_dma_grant", grant, 2'b10);
        chk("sim_dma_cmd", {mem_we, mem_addr}, {1'b0, 32'h200});
        finish_xfer("sim_dma", 2, 32'hBEEF_0200, 2'b10);
        dma_req = 0;
        step();

        // Both held: strict alternation
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10;
        dma_req = 1; dma_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            wait_mem_req($sformatf("alt%0d", k), 8, steps);
            chk($sformatf("alt%0d_grant", k), grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            finish_xfer($sformatf("alt%0d", k), 1, 32'h1000 + k, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        cpu_req = 0; dma_req = 0;
        step();

        // CPU withdraws and changes address mid-transfer
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        step();
        step();
        chk("frz_start", {mem_req, mem_addr}, {1'b1, 32'h100});
        cpu_req = 0; cpu_addr = 32'h8; cpu_we = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_hold", {mem_req, mem_we, mem_addr, grant}, {1'b1, 1'b0, 32'h100, 2'b01});
        end
        finish_xfer("frz", 0, 32'h600D, 2'b01);
        step();

        // Reset in the middle of a CPU transfer, then a stray mem_ready
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
        step();
        step();
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        cpu_req = 0;
        mem_ready = 1; mem_rdata = 32'h55;
        step();
        chk("rst_mid_no_ready", cpu_ready, 1'b0);
        check_reset_values("rst_mid");
        mem_ready = 0;
        step();
        check_reset_values("rst_mid_after");

        // Randomized traffic against the transaction model
        do_reset();
        exp_c = 0; exp_d = 0; lat_active = 0; lat = 0;
        c_gap = 0; d_gap = 0; c_other = 0; d_other = 0; n_done = 0;
        for (int cyc = 0; cyc < 3300; cyc++) begin
            draining = (cyc >= 3000);
            step();
            chk("rnd_ready", {cpu_ready, dma_ready, bus_err}, {exp_c, exp_d, 1'b0});
            if (exp_c) begin
                chk("rnd_cpu_rdata", cpu_rdata, exp_data);
                cpu_req = 0; c_gap = $urandom_range(0, 3); n_done++;
                if (dma_req) begin
                    d_other++;
                    chk("rnd_dma_starve", d_other <= 1, 1'b1);
                end
            end
            if (exp_d) begin
                chk("rnd_dma_rdata", dma_rdata, exp_data);
                dma_req = 0; d_gap = $urandom_range(0, 3); n_done++;
                if (cpu_req) begin
                    c_other++;
                    chk("rnd_cpu_starve", c_other <= 1, 1'b1);
                end
            end
            exp_c = 0; exp_d = 0;
            mem_ready = 0;
            if (mem_req) begin
                if (grant == 2'b01)
                    chk("rnd_cpu_cmd", {cpu_req, mem_we, mem_addr, mem_wdata},
                        {1'b1, cpu_we, cpu_addr, cpu_wdata});
                else if (grant == 2'b10)
                    chk("rnd_dma_cmd", {dma_req, mem_we, mem_addr, mem_wdata},
                        {1'b1, dma_we, dma_addr, dma_wdata});
                else
                    chk("rnd_grant_onehot", grant, 2'b01);
                if (!lat_active) begin
                    lat = $urandom_range(0, 6);
                    lat_active = 1;
                end
                if (lat == 0) begin
                    mem_ready = 1; mem_rdata = $urandom; exp_data = mem_rdata;
                    exp_c = (grant == 2'b01); exp_d = (grant == 2'b10);
                    lat_active = 0;
                end else begin
                    lat--;
                end
            end else begin
                lat_active = 0;
                mem_ready = ($urandom_range(0, 9) == 0);
                mem_rdata = $urandom;
            end
            if (!cpu_req) begin
                if (c_gap > 0) c_gap--;
                else if (!draining && $urandom_range(0, 2) == 0) begin
                    cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
                    c_other = 0;
                end
            end
            if (!dma_req) begin
                if (d_gap > 0) d_gap--;
                else if (!draining && $urandom_range(0, 2) == 0) begin
                    dma_req = 1; dma_we = 1'($urandom); dma_addr = $urandom; dma_wdata = $urandom;
                    d_other = 0;
                end
            end
        end
        chk("rnd_drained", {cpu_req, dma_req}, 2'b00);
        chk("rnd_activity", n_done > 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
